// File: rtl/fcmp_pkg.sv
// Shared types and constants for the arbitrated single-precision compare unit.
package fcmp_pkg;

  typedef enum logic [2:0] {
    FEQ  = 3'd0,
    FLT  = 3'd1,
    FLE  = 3'd2,
    FMIN = 3'd3,
    FMAX = 3'd4
  } fcmp_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StResp
  } fcmp_state_e;

  localparam logic [31:0] FCMP_TRUE  = 32'h1;
  localparam logic [31:0] FCMP_FALSE = 32'h0;

endpackage

// File: rtl/fcmp_core.sv
// Combinational sign-magnitude compare / min / max on IEEE-754 single bit patterns.
module fcmp_core
  import fcmp_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic [31:0] result
);

  logic eq;
  logic lt;

  always_comb begin
    eq = (x1 == x2);
    // -0 sorts below +0; no NaN or denormal handling
    unique case ({x1[31], x2[31]})
      2'b10:   lt = 1'b1;
      2'b01:   lt = 1'b0;
      2'b00:   lt = (x1[30:0] < x2[30:0]);
      default: lt = (x2[30:0] < x1[30:0]);
    endcase
  end

  always_comb begin
    result = FCMP_FALSE;
    case (op)
      FEQ:     result = eq ? FCMP_TRUE : FCMP_FALSE;
      FLT:     result = lt ? FCMP_TRUE : FCMP_FALSE;
      FLE:     result = (lt || eq) ? FCMP_TRUE : FCMP_FALSE;
      FMIN:    result = lt ? x1 : x2;
      FMAX:    result = lt ? x2 : x1;
      default: result = FCMP_FALSE;
    endcase
  end

endmodule

// File: rtl/fcmp_arbiter.sv
// Round-robin arbiter sharing one registered compare datapath between NREQ requesters.
module fcmp_arbiter
  import fcmp_pkg::*;
#(
  parameter int unsigned NREQ = 2,
  parameter int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*3-1:0]    req_op,
  input  logic [NREQ*32-1:0]   req_x1,
  input  logic [NREQ*32-1:0]   req_x2,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 busy
);

  fcmp_state_e state_q, state_d;

  logic [IDW-1:0] last_g_q;
  logic [2:0]     op_q;
  logic [31:0]    x1_q, x2_q;
  logic [IDW-1:0] id_q;
  logic [31:0]    rsp_data_q;
  logic [IDW-1:0] rsp_id_q;

  logic             any_valid;
  logic             grant_en;
  logic [IDW-1:0]   grant_idx;
  logic [IDW:0]     start, off, sum;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]  rot;
  logic [2:0]       sel_op;
  logic [31:0]      sel_x1, sel_x2;
  logic [31:0]      core_result;

  assign any_valid = |req_valid;
  assign grant_en  = (state_q == StIdle) && any_valid;

  // Rotate the valid vector so the search always starts at bit 0, then map back.
  always_comb begin
    start = (IDW+1)'(last_g_q) + (IDW+1)'(1);
    dbl   = {req_valid, req_valid};
    rot   = NREQ'(dbl >> start);
    off   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = (IDW+1)'(i);
    end
    sum = start + off;
    if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
    grant_idx = sum[IDW-1:0];
  end

  always_comb begin
    sel_op = '0;
    sel_x1 = '0;
    sel_x2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        sel_op = req_op[3*i +: 3];
        sel_x1 = req_x1[32*i +: 32];
        sel_x2 = req_x2[32*i +: 32];
      end
    end
  end

  // Gated by rst so no accept is signalled while reset is held.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant_en && !rst && (grant_idx == IDW'(i));
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (any_valid) state_d = StCalc;
      StCalc:  state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  fcmp_core u_core (
    .op     (op_q),
    .x1     (x1_q),
    .x2     (x2_q),
    .result (core_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      last_g_q   <= IDW'(NREQ - 1);
      op_q       <= '0;
      x1_q       <= '0;
      x2_q       <= '0;
      id_q       <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant_en) begin
        last_g_q <= grant_idx;
        op_q     <= sel_op;
        x1_q     <= sel_x1;
        x2_q     <= sel_x2;
        id_q     <= grant_idx;
      end
      if (state_q == StCalc) begin
        rsp_data_q <= core_result;
        rsp_id_q   <= id_q;
      end
    end
  end

  assign rsp_valid = (state_q == StResp);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_fcmp_arbiter.sv
// Scoreboard bench: behavioural arbitration/compare model, monitor compares every cycle.
module tb_fcmp_arbiter;

  localparam int NREQ = 2;
  localparam int IDW  = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid, req_ready;
  logic [NREQ*3-1:0]  req_op;
  logic [NREQ*32-1:0] req_x1, req_x2;
  logic               rsp_valid, rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [31:0]        rsp_data;
  logic               busy;

  fcmp_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_x1    (req_x1),
    .req_x2    (req_x2),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  typedef struct {
    int          id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   outstanding = 0;
  int   due = 0;
  int   free_at = 0;
  int   last_g = NREQ - 1;
  bit   hs[NREQ];

  // Map a sign-magnitude pattern onto a signed integer line; -0 lands just below +0.
  function automatic longint fkey(input logic [31:0] v);
    longint m;
    m = longint'(v[30:0]);
    return v[31] ? (-m - 1) : m;
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    bit lt, eq;
    lt = fkey(a) < fkey(b);
    eq = (a == b);
    case (op)
      3'd0:    return {31'b0, eq};
      3'd1:    return {31'b0, lt};
      3'd2:    return {31'b0, lt | eq};
      3'd3:    return lt ? a : b;
      3'd4:    return lt ? b : a;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (last + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Monitor + model
  always @(negedge clk) begin
    logic [NREQ-1:0] exp_ready;
    bit              exp_v;
    int              g;
    cyc++;
    if (rst) begin
      sb.delete();
      outstanding = 0;
      last_g      = NREQ - 1;
      free_at     = 0;
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
      check("rst_rsp_data", rsp_data, 32'h0);
      check("rst_rsp_id", 32'(rsp_id), 32'h0);
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
    end else begin
      check("busy", {31'b0, busy}, {31'b0, outstanding});
      exp_v = outstanding && (cyc >= due);
      check("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_v});
      if (rsp_valid && exp_v && sb.size() > 0) begin
        check("rsp_id", 32'(rsp_id), 32'(sb[0].id));
        check("rsp_data", rsp_data, sb[0].data);
        if (rsp_ready) begin
          void'(sb.pop_front());
          outstanding = 0;
          free_at     = cyc + 1;
        end
      end
      exp_ready = '0;
      if (!outstanding && cyc >= free_at && |req_valid) begin
        g = pick(req_valid, last_g);
        exp_ready[g] = 1'b1;
        sb.push_back('{id: g, data: ref_result(req_op[3*g +: 3], req_x1[32*g +: 32],
                                               req_x2[32*g +: 32])});
        outstanding = 1;
        due         = cyc + 2;
        last_g      = g;
        hs[g]       = 1;
      end
      check("req_ready", 32'(req_ready), 32'(exp_ready));
    end
  end

  task automatic drive(input int r, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    req_valid[r]        = 1'b1;
    req_op[3*r +: 3]    = op;
    req_x1[32*r +: 32]  = a;
    req_x2[32*r +: 32]  = b;
  endtask

  task automatic wait_hs(input int r);
    int n = 0;
    while (!hs[r] && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!hs[r]) begin
      errors++;
      $display("FAIL grant_timeout req%0d: got no grant expected grant within 60 cycles", r);
    end
    hs[r] = 0;
  endtask

  task automatic send(input int r, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    @(posedge clk);
    #1;
    hs[r] = 0;
    drive(r, op, a, b);
    wait_hs(r);
    req_valid[r] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((outstanding || sb.size() > 0) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (outstanding || sb.size() > 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  function automatic logic [31:0] rand_fp();
    case ($urandom % 5)
      0:       return 32'h0000_0000;
      1:       return 32'h8000_0000;
      2:       return {$urandom_range(1, 0) == 1, 8'h7f, 23'($urandom_range(7, 0))};
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_rand(input int r);
    logic [31:0] a, b;
    a = rand_fp();
    case ($urandom % 4)
      0:       b = a;
      1:       b = a ^ 32'h8000_0000;
      default: b = rand_fp();
    endcase
    drive(r, 3'($urandom % 8), a, b);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_x1    = '0;
    req_x2    = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) hs[i] = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Basic sign cases
    send(0, 3'd1, 32'hBF80_0000, 32'h3F80_0000);
    drain();
    send(0, 3'd1, 32'hC000_0000, 32'hBF80_0000);
    send(0, 3'd4, 32'hC000_0000, 32'hBF80_0000);
    send(0, 3'd0, 32'h8000_0000, 32'h0000_0000);
    send(0, 3'd2, 32'h8000_0000, 32'h0000_0000);
    send(1, 3'd3, 32'h3F80_0000, 32'h3F80_0000);
    send(1, 3'd0, 32'h3F80_0000, 32'h3F80_0000);
    drain();

    // Both requesters continuously valid: grants must alternate
    @(posedge clk);
    #1;
    for (int r = 0; r < NREQ; r++) begin
      hs[r] = 0;
      drive_rand(r);
    end
    repeat (14) begin
      @(posedge clk);
      #1;
      for (int r = 0; r < NREQ; r++) begin
        if (hs[r]) begin
          hs[r] = 0;
          drive_rand(r);
        end
      end
    end
    req_valid = '0;
    drain();
    for (int r = 0; r < NREQ; r++) hs[r] = 0;

    // Back-pressure with a competing request waiting
    rsp_ready = 1'b0;
    send(0, 3'd1, 32'h4000_0000, 32'h3F80_0000);
    drive(1, 3'd4, 32'h4040_0000, 32'h3F80_0000);
    repeat (7) @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_hs(1);
    req_valid[1] = 1'b0;
    drain();

    // Illegal opcode, then a nonzero response so the reset clear is visible
    send(0, 3'd6, 32'h3F80_0000, 32'h4000_0000);
    send(1, 3'd1, 32'hBF80_0000, 32'h3F80_0000);
    drain();

    // Reset during CALC
    send(0, 3'd2, 32'h3F80_0000, 32'h4000_0000);
    rst = 1'b1;
    #1;
    check("rst_now_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("rst_now_busy", {31'b0, busy}, 32'h0);
    check("rst_now_rsp_data", rsp_data, 32'h0);
    check("rst_now_rsp_id", 32'(rsp_id), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hs[1] = 0;
    drive(1, 3'd3, 32'hC000_0000, 32'h3F80_0000);
    @(posedge clk);
    #1;
    check("rst_first_grant_req1", {31'b0, hs[1]}, 32'h1);
    hs[1] = 0;
    req_valid[1] = 1'b0;
    drain();

    // Random traffic with random back-pressure
    repeat (800) begin
      @(posedge clk);
      #1;
      rsp_ready = ($urandom % 4) != 0;
      for (int r = 0; r < NREQ; r++) begin
        if (hs[r]) begin
          hs[r] = 0;
          req_valid[r] = 1'b0;
        end
        if (!req_valid[r] && ($urandom % 3) == 0) drive_rand(r);
        else if (req_valid[r] && ($urandom % 25) == 0) req_valid[r] = 1'b0;
      end
    end
    req_valid = '0;
    rsp_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fcmp_arbiter.md
Name: fcmp_arbiter

Overview:
- Shares one registered single-precision compare datapath between NREQ requesters, e.g. the integer-core FPU issue port and the vector/test port.
- Round-robin arbitration.
- Supported ops: FEQ, FLT, FLE, FMIN, FMAX.
- Valid/ready handshake on both request and response sides.
- Sits between the FPU decode stage and writeback.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDW, $clog2(NREQ) (min 1), width of the requester ID on the response.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_op  in  NREQ*3  per-requester opcode; requester i uses bits [3i+2:3i].
- req_x1  in  NREQ*32  per-requester operand 1 (IEEE-754 single).
- req_x2  in  NREQ*32  per-requester operand 2.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  index of the requester that is being answered.
- rsp_data  out  32  result.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Opcodes: FEQ=0, FLT=1, FLE=2, FMIN=3, FMAX=4. Codes 5..7 are illegal.
- Ordering is sign-magnitude with no NaN/denormal special cases.
  - sign(x1)=1, sign(x2)=0: x1<x2 is true. Note -0 < +0 is true.
  - sign(x1)=0, sign(x2)=1: x1<x2 is false.
  - Both positive: x1[30:0] < x2[30:0], unsigned.
  - Both negative: x2[30:0] < x1[30:0], unsigned.
- Results:
  - FEQ = (x1 == x2), bitwise over 32 bits.
  - FLT = lt(x1,x2).
  - FLE = FLT | FEQ.
  - Compare ops return 32'h1 for true, 32'h0 for false.
  - FMIN returns FLT ? x1 : x2. FMAX returns FLT ? x2 : x1.
  - Illegal ops return 32'h0 and still produce a response.
- FSM states: IDLE, CALC, RESP.
  - IDLE: if any req_valid, grant the winner. req_ready[g]=1 combinationally in this cycle only. Capture op/x1/x2/id into operand registers. Next state CALC. With no valid request, stay in IDLE.
  - CALC: the compare core evaluates the captured operands. rsp_data and rsp_id are registered at the end of the cycle. Next state RESP.
  - RESP: rsp_valid=1. rsp_data and rsp_id are held stable until rsp_ready. On rsp_valid&rsp_ready, go to IDLE.
- req_ready is 0 in CALC and RESP.
- Latency: handshake in cycle T, rsp_valid asserted in T+2. Peak throughput is 1 op per 3 cycles when rsp_ready is held high.
- Arbitration: round-robin pointer last_g.
  - Search starts at last_g+1 (mod NREQ), increasing index.
  - last_g updates to the granted index on grant only.
  - Reset value of last_g is NREQ-1, so requester 0 wins first.
- Requester rules:
  - A requester must hold valid and payload until its ready. The block samples the payload only in the grant cycle.
  - Dropping valid before grant is legal; no grant is issued to it.
- Reset (async, any state, including mid-CALC/RESP):
  - state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0, busy=0, last_g=NREQ-1.
  - The in-flight operation is discarded, with no response.
  - The first grant is possible in the first cycle after rst deasserts.
- Simultaneous events: rsp handshake in RESP and new req_valid in the same cycle: the new request is not granted until the following cycle, in IDLE.

Decomposition:
- Shared package fcmp_pkg holds:
  - opcode enum fcmp_op_e (FEQ..FMAX).
  - state enum fcmp_state_e.
  - constants FCMP_TRUE=32'h1 and FCMP_FALSE=32'h0.
- Sub-module fcmp_core: purely combinational.
  - Inputs: op, x1, x2. Output: 32-bit result.
  - Implements the ordering and result rules above.
- fcmp_arbiter contains the FSM, the round-robin picker and the registers.

Test Plan:
- Reset, then req0: FLT x1=32'hBF800000 (-1.0), x2=32'h3F800000 (1.0) -> req_ready[0] in T, rsp_valid in T+2, rsp_data=1, rsp_id=0.
- Both negative: FLT x1=32'hC0000000 (-2.0), x2=32'hBF800000 (-1.0) -> 1. FMAX of the same operands -> 32'hBF800000. FEQ 32'h80000000 vs 32'h00000000 -> 0. FLE of the same pair -> 1.
- req0 and req1 both valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; each response 3 cycles apart.
- Back-pressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid stays 1, rsp_data/rsp_id stable, req_ready=0, no new grant. Release rsp_ready -> IDLE the next cycle.
- Illegal op 3'd6 -> response issued with rsp_data=0. Assert rst during CALC -> outputs cleared immediately, no response. After release, req1 alone is granted first cycle.
- FMIN x1=32'h3F800000, x2=32'h3F800000 -> 32'h3F800000 (x2 path). FEQ on the same pair -> 1.
